// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the 2x2 stride-2 pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int POOL_MIN_DIM = 2;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit dims_ok(input int img_w, input int img_h);
        return (img_w >= POOL_MIN_DIM) && (img_h >= POOL_MIN_DIM) &&
               (img_w % 2 == 0) && (img_h % 2 == 0);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding horizontal partials from the even row of each window pair.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int W     = 9,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    // No reset: every entry is written on the even row before the odd row reads it.
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 max/average pooling over a raster-scan pixel stream with frame-length checking.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = cnt_w(LB_D);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if (!dims_ok(IMG_W, IMG_H)) begin : g_bad_dims
        $error("pool2d_stream: IMG_W and IMG_H must be even and >= 2");
    end

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_pair;
    pool_mode_e        r_mode;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_err;

    logic              w_accept;
    logic              w_end_col;
    logic              w_final;
    logic              w_early_last;
    logic              w_missing_last;
    logic              w_prod;
    logic              w_load;
    logic              w_lb_we;
    logic [LB_AW-1:0]  w_lb_idx;
    logic [DATA_W:0]   w_h;
    logic [DATA_W:0]   w_lb_rd;
    logic [DATA_W+1:0] w_sum4;
    logic [DATA_W-1:0] w_res;

    assign w_end_col      = (r_col == COL_LAST);
    assign w_final        = w_end_col && (r_row == ROW_LAST);
    assign w_prod         = r_row[0] && r_col[0];
    assign in_ready       = !(w_prod && r_out_valid && !out_ready);
    assign w_accept       = in_valid && in_ready;
    assign w_early_last   = in_last && !w_final;
    assign w_missing_last = w_final && !in_last;
    // A premature in_last throws the current window away, so neither store nor emit it.
    assign w_load         = w_accept && w_prod && !w_early_last;
    assign w_lb_we        = w_accept && !r_row[0] && r_col[0] && !w_early_last;
    assign w_lb_idx       = LB_AW'(r_col >> 1);

    always_comb begin
        w_h = '0;
        if (r_mode == POOL_AVG) begin
            w_h = {1'b0, r_pair} + {1'b0, in_data};
        end else begin
            w_h = {1'b0, (in_data > r_pair) ? in_data : r_pair};
        end
    end

    pool_line_buf #(
        .DEPTH (LB_D),
        .W     (DATA_W + 1),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_idx),
        .i_wdata (w_h),
        .i_raddr (w_lb_idx),
        .o_rdata (w_lb_rd)
    );

    assign w_sum4 = {1'b0, w_h} + {1'b0, w_lb_rd};

    always_comb begin
        w_res = '0;
        if (r_mode == POOL_AVG) begin
            w_res = DATA_W'(w_sum4 >> 2);
        end else begin
            w_res = (w_h[DATA_W-1:0] > w_lb_rd[DATA_W-1:0]) ? w_h[DATA_W-1:0]
                                                             : w_lb_rd[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pair <= '0;
            r_mode <= POOL_MAX;
        end else if (w_accept) begin
            if (w_early_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_end_col) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if (!r_col[0]) begin
                r_pair <= in_data;
            end
            if ((r_col == '0) && (r_row == '0)) begin
                r_mode <= pool_mode_e'(mode);
            end
        end
    end

    // Load wins over drain, so a simultaneous drain+load keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && (w_early_last || w_missing_last);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_last  <= w_final;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream on a 4x4 frame: directed scenarios plus randomized frames vs a window model.
module tb_pool2d_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    typedef int pix_t [NPIX];
    typedef int res_t [NOUT];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err;

    int tests = 0;
    int fails = 0;
    bit bp_on;

    int got_data[$];
    int got_last[$];
    int stall_vals[$];
    int err_cnt = 0;

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    // Inputs change at posedge+2; the negedge view equals what the next posedge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_data.push_back(int'(out_data));
                got_last.push_back(int'(out_last));
            end
            if (err) err_cnt++;
            if (in_valid && !in_ready) stall_vals.push_back(int'(in_data));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_pool(input pix_t px, input bit avg);
        res_t r;
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                int a, b, c, d, m;
                a = px[(2 * wr) * W + 2 * wc];
                b = px[(2 * wr) * W + 2 * wc + 1];
                c = px[(2 * wr + 1) * W + 2 * wc];
                d = px[(2 * wr + 1) * W + 2 * wc + 1];
                m = a;
                if (b > m) m = b;
                if (c > m) m = c;
                if (d > m) m = d;
                r[wr * (W / 2) + wc] = avg ? (a + b + c + d) / 4 : m;
            end
        end
        return r;
    endfunction

    function automatic pix_t seq_frame();
        pix_t p;
        for (int i = 0; i < NPIX; i++) p[i] = i + 1;
        return p;
    endfunction

    function automatic pix_t const_frame(input int v);
        pix_t p;
        for (int i = 0; i < NPIX; i++) p[i] = v;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input bit last, input int gap);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d[DW-1:0];
        in_last  = last;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic send_frame(input pix_t px, input bit avg, input bit toggle,
                              input bit with_last, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (i == 0) mode = avg;
            else if (i == 1 && toggle) mode = !avg;
            push(px[i], with_last && (i == NPIX - 1), gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic wait_outs(input int target);
        for (int k = 0; k < 200 && got_data.size() < target; k++) tick();
    endtask

    task automatic check_outs(input string tag, input int base, input res_t exp);
        wait_outs(base + NOUT);
        chk($sformatf("%s_count", tag), got_data.size() - base, NOUT);
        if (got_data.size() >= base + NOUT) begin
            for (int i = 0; i < NOUT; i++) begin
                chk($sformatf("%s_data%0d", tag, i), got_data[base + i], exp[i]);
                chk($sformatf("%s_last%0d", tag, i), got_last[base + i], (i == NOUT - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic run_check(input string tag, input pix_t px, input bit avg, input bit toggle);
        int base, e0, s0;
        base = got_data.size();
        e0   = err_cnt;
        s0   = stall_vals.size();
        send_frame(px, avg, toggle, 1'b1, 1'b0);
        check_outs(tag, base, ref_pool(px, avg));
        chk($sformatf("%s_err", tag), err_cnt - e0, 0);
        chk($sformatf("%s_stalls", tag), stall_vals.size() - s0, 0);
    endtask

    initial begin
        pix_t px;
        int   base, e0, s0;
        bit   avg, tog;

        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        bp_on     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        run_check("max_seq", seq_frame(), 1'b0, 1'b0);
        run_check("avg_seq", seq_frame(), 1'b1, 1'b0);
        run_check("max_255", const_frame(255), 1'b0, 1'b0);
        run_check("avg_255", const_frame(255), 1'b1, 1'b0);

        // Backpressure: hold out_ready low for 6 cycles once result 6 is up.
        base = got_data.size();
        s0   = stall_vals.size();
        fork
            send_frame(seq_frame(), 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                for (int n = 0; n < 100; n++) begin
                    tick();
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                repeat (6) tick();
                out_ready = 1'b1;
            end
        join
        check_outs("bp", base, ref_pool(seq_frame(), 1'b0));
        chk("bp_stalled", (stall_vals.size() > s0) ? 1 : 0, 1);
        for (int i = s0; i < stall_vals.size(); i++) chk("bp_stall_pixel", stall_vals[i], 8);

        // Premature in_last on pixel 10, then a clean frame.
        base = got_data.size();
        e0   = err_cnt;
        mode = 1'b0;
        for (int i = 0; i < 10; i++) push(i + 1, i == 9, 0);
        repeat (3) tick();
        chk("early_last_err", err_cnt - e0, 1);
        wait_outs(base + 2);
        chk("early_last_count", got_data.size() - base, 2);
        if (got_data.size() >= base + 2) begin
            chk("early_last_d0", got_data[base], 6);
            chk("early_last_d1", got_data[base + 1], 8);
            chk("early_last_l1", got_last[base + 1], 0);
        end
        run_check("after_early", seq_frame(), 1'b0, 1'b0);

        // Final position accepted without in_last: counters still wrap.
        base = got_data.size();
        e0   = err_cnt;
        send_frame(seq_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("no_last", base, ref_pool(seq_frame(), 1'b1));
        chk("no_last_err", err_cnt - e0, 1);
        run_check("after_no_last", seq_frame(), 1'b0, 1'b0);

        // Reset after 7 pixels.
        mode = 1'b1;
        for (int i = 0; i < 7; i++) push(i + 1, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        run_check("after_rst", seq_frame(), 1'b0, 1'b0);

        run_check("toggle_avg", seq_frame(), 1'b1, 1'b1);
        run_check("toggle_max", seq_frame(), 1'b0, 1'b1);

        // Random frames with random gaps, mode changes and backpressure.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NPIX; i++) px[i] = int'($urandom_range(0, 255));
            avg  = 1'($urandom_range(0, 1));
            tog  = 1'($urandom_range(0, 1));
            base = got_data.size();
            e0   = err_cnt;
            bp_on = 1'b1;
            fork
                begin
                    send_frame(px, avg, tog, 1'b1, 1'b1);
                    bp_on = 1'b0;
                end
                begin
                    while (bp_on) begin
                        tick();
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    out_ready = 1'b1;
                end
            join
            check_outs($sformatf("rnd%0d", f), base, ref_pool(px, avg));
            chk($sformatf("rnd%0d_err", f), err_cnt - e0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Parametrised 2×2, stride-2 pooling engine for a single-channel raster-scan pixel stream, with run-time max/average selection. Sits between a conv layer's output stream and the next layer's input, replacing naive every-other-sample decimation with true 2-D window pooling. Uses valid/ready handshakes on both sides, a half-width line buffer, and frame-boundary tracking with error reporting.

## Interface
- `DATA_W`, default 8: pixel width (unsigned).
- `IMG_W`, default 28: frame width in pixels. Must be even and ≥ 2.
- `IMG_H`, default 28: frame height in rows. Must be even and ≥ 2.

Ports:
- `clk`  in  1  single clock for the block; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  pooling mode: 0 = max, 1 = average. Sampled per frame.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  DATA_W  input pixel.
- `in_last`  in  1  marks the final pixel of a frame.
- `out_valid`  out  1  pooled result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  DATA_W  pooled result.
- `out_last`  out  1  marks the final pooled result of a frame.
- `err`  out  1  one-cycle pulse on a frame-length mismatch.

## Operation
- **Accept rule.** A pixel is accepted when `in_valid && in_ready`.
- **Position tracking.** `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1, advancing per accepted pixel.
  - At `col == IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At the final pixel, both counters wrap to 0.
- **Mode latch.** `mode` is latched on acceptance of pixel (0,0). Changes to `mode` mid-frame are ignored.
- **Even col:** the pixel is held in a pair register.
- **Odd col:** the pixel is combined with the pair register to form a horizontal partial `h`.
  - Max mode: `h` = max of the two pixels.
  - Average mode: `h` = sum of the two pixels, DATA_W+1 bits.
- **Even row, odd col:** `h` is written to line-buffer entry `col>>1`.
- **Odd row, odd col:** `h` is combined with line-buffer entry `col>>1` to form the result, which is loaded into the output register.
  - Max mode: max of the two.
  - Average mode: 4-pixel sum in DATA_W+2 bits, shifted right by 2 (floor). No rounding; the result never overflows.
- **Output last.** `out_last` is set with the result of window (IMG_H-2..IMG_H-1, IMG_W-2..IMG_W-1).
- **in_ready.** `in_ready` = NOT(`row` odd AND `col` odd AND `out_valid` AND NOT `out_ready`).
  - Stall only occurs on a producing position while the output register is occupied.
  - There is a combinational path from `out_ready` to `in_ready`.
- **Output register.** The output register is cleared when `out_valid && out_ready` and no new result is loaded in the same cycle. Simultaneous drain and load is a valid-held handover.
- **Frame error.** `err` pulses for one cycle in either case:
  - `in_last` is accepted at a position other than (IMG_H-1, IMG_W-1). The counters then resync to (0,0) and the partial window is discarded. No output is produced for the discarded window.
  - The final position is accepted without `in_last`. The counters wrap normally.

## Timing
- **Reset values** (while `rst_n` = 0): `out_valid`=0, `out_data`=0, `out_last`=0, `err`=0, counters=0, pair register=0, latched mode=0 (max).
- `in_ready` is 1 out of reset.
- Line-buffer contents are don't-care after reset; each entry is always written before it is read.
- **Latency.** `out_valid` rises the cycle after the odd-row, odd-col pixel is accepted.
- **Throughput.** One pixel per cycle with no stall if `out_ready` = 1. One result per four input pixels.
- **Mid-frame reset.** Reset discards all in-flight state. The next accepted pixel is (0,0).
- **err timing.** `err` is registered and asserted the cycle after the offending acceptance.

## Structure
- **Package `pool_pkg`:**
  - `pool_mode_e` enum: `POOL_MAX`=0, `POOL_AVG`=1.
  - `clog2`-derived width constants for the counters.
  - Elaboration-time parameter check that IMG_W and IMG_H are even.
- **Sub-module `pool_line_buf`:**
  - IMG_W/2 entries × (DATA_W+1) bits.
  - One synchronous write port.
  - One asynchronous read port, index `col>>1`.
  - Maps to distributed RAM or flops.
- The top level holds the counters, pair register, mode latch, combine logic and output register.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, DATA_W=8, with input pixels 1..16 in raster order unless stated.
- **Max mode, `out_ready`=1:** outputs 6, 8, 14, 16. `out_last` only with 16. No stalls.
- **Average mode, same frame:** outputs 3, 5, 11, 13 (floor of 3.5, 5.5, 11.5, 13.5).
- **All pixels 255, both modes:** every output is 255; no overflow in average mode.
- **Backpressure:** `out_ready`=0 for 6 cycles after result 6 appears.
  - `in_ready` drops only when pixel 8 (row 1, col 3) is presented.
  - Results 6 and 8 are delivered in order, with no loss or duplication.
- **in_last on pixel 10:** one `err` pulse. The next pixel is treated as (0,0). A following clean frame gives 6, 8, 14, 16.
- **Reset mid-frame:** `rst_n` pulsed low after 7 pixels. All outputs read 0 during reset. A fresh frame gives correct results.
- **Mode toggled mid-frame:** results follow the mode latched at pixel (0,0).
